// File: rtl/line_pkg.sv
// Shared definitions for the line-following drive sequencer.
//   state_t      : FSM state encoding (also driven out on state_o)
//   FWD/REV/...  : 2-bit L298 direction pin pairs {inA, inB}
//   LAST_L/R     : remembered turn direction used by the search pivot
//   sensor_decode: common line-sensor decode for follow/veer/search
//   drive_en     : enable pin value for a direction and PWM phase
package line_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FOLLOW   = 3'd1,
    VEER_L   = 3'd2,
    VEER_R   = 3'd3,
    SEARCH   = 3'd4,
    OBSTACLE = 3'd5,
    HALT     = 3'd6
  } state_t;

  localparam logic [1:0] FWD   = 2'b10;
  localparam logic [1:0] REV   = 2'b01;
  localparam logic [1:0] BRAKE = 2'b11;
  localparam logic [1:0] COAST = 2'b00;

  localparam logic LAST_L = 1'b0;
  localparam logic LAST_R = 1'b1;

  // pat = {s1, s2, s3, s4}; unrecognised patterns keep the current state.
  function automatic state_t sensor_decode(input logic [3:0] pat, input state_t cur);
    state_t nxt;
    if ((pat == 4'b0110) || (pat == 4'b1111)) begin
      nxt = FOLLOW;
    end else if (pat == 4'b0000) begin
      nxt = SEARCH;
    end else if (pat[1:0] == 2'b00) begin
      // pattern is nonzero here, so only the left pair can be set
      nxt = VEER_L;
    end else if (pat[3:2] == 2'b00) begin
      nxt = VEER_R;
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  // Brake holds the enable high; coast drops it; drive modes follow the PWM.
  function automatic logic drive_en(input logic [1:0] dir, input logic pwm);
    logic en;
    case (dir)
      FWD, REV: en = pwm;
      BRAKE:    en = 1'b1;
      default:  en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/drive_pwm.sv
// Shared free-running PWM counter with one comparator per motor channel.
//   clk, rst_n       : clock, async active-low reset (counter only resets here)
//   duty_l, duty_r   : duty values, en high while counter < duty
//   pwm_l, pwm_r     : raw PWM phases (combinational from counter and duty)
module drive_pwm #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PWM_BITS-1:0] duty_l,
  input  logic [PWM_BITS-1:0] duty_r,
  output logic                pwm_l,
  output logic                pwm_r
);

  logic [PWM_BITS-1:0] r_cnt;

  // Free-running counter, wraps naturally at 2^PWM_BITS-1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {PWM_BITS{1'b0}};
    end else begin
      r_cnt <= r_cnt + {{(PWM_BITS-1){1'b0}}, 1'b1};
    end
  end

  // duty 0 never enables; full-scale duty leaves exactly one low count.
  assign pwm_l = (r_cnt < duty_l);
  assign pwm_r = (r_cnt < duty_r);

endmodule

// File: rtl/line_follow_ctrl.sv
// Drive sequencer for a two-motor line follower.
//   clk, rst_n         : clock, async active-low reset
//   run                : drive enable, 0 forces IDLE
//   s1..s4             : line sensors (s1 leftmost), asynchronous, 1 = line
//   prox               : proximity, asynchronous, 0 = obstacle
//   en1, in1, in2      : left channel PWM enable and direction (registered)
//   en2, in3, in4      : right channel PWM enable and direction (registered)
//   state_o            : current FSM state for debug LEDs
module line_follow_ctrl
  import line_pkg::*;
#(
  parameter int PWM_BITS    = 8,
  parameter int DUTY_FWD    = 200,
  parameter int DUTY_TURN   = 120,
  parameter int LOST_CYCLES = 50000,
  parameter int OBST_HOLD   = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       s1,
  input  logic       s2,
  input  logic       s3,
  input  logic       s4,
  input  logic       prox,
  output logic       en1,
  output logic       in1,
  output logic       in2,
  output logic       en2,
  output logic       in3,
  output logic       in4,
  output logic [2:0] state_o
);

  localparam logic [PWM_BITS-1:0] C_DUTY_FWD  = PWM_BITS'(DUTY_FWD);
  localparam logic [PWM_BITS-1:0] C_DUTY_TURN = PWM_BITS'(DUTY_TURN);
  localparam logic [PWM_BITS-1:0] C_DUTY_ZERO = {PWM_BITS{1'b0}};
  localparam logic [15:0]         C_LOST_LAST = 16'(LOST_CYCLES - 1);
  localparam logic [15:0]         C_HOLD_LAST = 16'(OBST_HOLD - 1);

  logic [3:0]          r_sens_meta, r_sens_sync;
  logic                r_prox_meta, r_prox_sync;
  state_t              r_state, w_next_state;
  logic                r_last_dir, w_last_dir_next;
  logic [15:0]         r_search_cnt, w_search_cnt_next;
  logic [15:0]         r_hold_cnt, w_hold_cnt_next;
  logic [1:0]          w_dir_l, w_dir_r;
  logic [PWM_BITS-1:0] w_duty_l, w_duty_r;
  logic                w_pwm_l, w_pwm_r;
  logic                r_en1, r_in1, r_in2, r_en2, r_in3, r_in4;

  // Two-flop synchronizers; prox resets to 0 so the robot starts obstacle-safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sens_meta <= 4'b0000;
      r_sens_sync <= 4'b0000;
      r_prox_meta <= 1'b0;
      r_prox_sync <= 1'b0;
    end else begin
      r_sens_meta <= {s1, s2, s3, s4};
      r_sens_sync <= r_sens_meta;
      r_prox_meta <= prox;
      r_prox_sync <= r_prox_meta;
    end
  end

  // Next-state, timer and last-direction logic.
  always_comb begin
    w_next_state      = r_state;
    w_search_cnt_next = 16'd0;
    w_hold_cnt_next   = 16'd0;
    if (!run) begin
      w_next_state = IDLE;
    end else if (!r_prox_sync && (r_state != IDLE)) begin
      // entering or staying in OBSTACLE with prox low keeps the hold count at 0
      w_next_state = OBSTACLE;
    end else begin
      case (r_state)
        IDLE: begin
          w_next_state = FOLLOW;
        end
        FOLLOW, VEER_L, VEER_R: begin
          w_next_state = sensor_decode(r_sens_sync, r_state);
        end
        SEARCH: begin
          w_search_cnt_next = r_search_cnt + 16'd1;
          if (r_sens_sync != 4'b0000) begin
            w_next_state = sensor_decode(r_sens_sync, r_state);
          end else if (r_search_cnt == C_LOST_LAST) begin
            w_next_state = HALT;
          end else begin
            w_next_state = SEARCH;
          end
        end
        OBSTACLE: begin
          // prox_s is known high here
          if (r_hold_cnt == C_HOLD_LAST) begin
            w_next_state = FOLLOW;
          end else begin
            w_next_state    = OBSTACLE;
            w_hold_cnt_next = r_hold_cnt + 16'd1;
          end
        end
        HALT: begin
          w_next_state = HALT;
        end
        default: begin
          w_next_state = IDLE;
        end
      endcase
    end

    // The search counter must read 0 on every entry into SEARCH.
    w_search_cnt_next = (w_next_state == SEARCH) ? w_search_cnt_next : 16'd0;

    if (w_next_state == VEER_L) begin
      w_last_dir_next = LAST_L;
    end else if (w_next_state == VEER_R) begin
      w_last_dir_next = LAST_R;
    end else begin
      w_last_dir_next = r_last_dir;
    end
  end

  // FSM state, timers and remembered turn direction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_last_dir   <= LAST_L;
      r_search_cnt <= 16'd0;
      r_hold_cnt   <= 16'd0;
    end else begin
      r_state      <= w_next_state;
      r_last_dir   <= w_last_dir_next;
      r_search_cnt <= w_search_cnt_next;
      r_hold_cnt   <= w_hold_cnt_next;
    end
  end

  // Per-state direction and duty for each channel.
  always_comb begin
    w_dir_l  = COAST;
    w_dir_r  = COAST;
    w_duty_l = C_DUTY_ZERO;
    w_duty_r = C_DUTY_ZERO;
    case (r_state)
      FOLLOW: begin
        w_dir_l  = FWD;
        w_dir_r  = FWD;
        w_duty_l = C_DUTY_FWD;
        w_duty_r = C_DUTY_FWD;
      end
      VEER_L: begin
        w_dir_l  = FWD;
        w_dir_r  = FWD;
        w_duty_l = C_DUTY_TURN;
        w_duty_r = C_DUTY_FWD;
      end
      VEER_R: begin
        w_dir_l  = FWD;
        w_dir_r  = FWD;
        w_duty_l = C_DUTY_FWD;
        w_duty_r = C_DUTY_TURN;
      end
      SEARCH: begin
        // pivot toward the side the line was last seen on
        w_duty_l = C_DUTY_TURN;
        w_duty_r = C_DUTY_TURN;
        if (r_last_dir == LAST_L) begin
          w_dir_l = REV;
          w_dir_r = FWD;
        end else begin
          w_dir_l = FWD;
          w_dir_r = REV;
        end
      end
      OBSTACLE, HALT: begin
        w_dir_l = BRAKE;
        w_dir_r = BRAKE;
      end
      default: begin
        w_dir_l = COAST;
        w_dir_r = COAST;
      end
    endcase
  end

  drive_pwm #(
    .PWM_BITS(PWM_BITS)
  ) u_drive_pwm (
    .clk   (clk),
    .rst_n (rst_n),
    .duty_l(w_duty_l),
    .duty_r(w_duty_r),
    .pwm_l (w_pwm_l),
    .pwm_r (w_pwm_r)
  );

  // Output register: motor pins change one clock after the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en1 <= 1'b0;
      r_in1 <= 1'b0;
      r_in2 <= 1'b0;
      r_en2 <= 1'b0;
      r_in3 <= 1'b0;
      r_in4 <= 1'b0;
    end else begin
      r_en1 <= drive_en(w_dir_l, w_pwm_l);
      r_in1 <= w_dir_l[1];
      r_in2 <= w_dir_l[0];
      r_en2 <= drive_en(w_dir_r, w_pwm_r);
      r_in3 <= w_dir_r[1];
      r_in4 <= w_dir_r[0];
    end
  end

  assign en1     = r_en1;
  assign in1     = r_in1;
  assign in2     = r_in2;
  assign en2     = r_en2;
  assign in3     = r_in3;
  assign in4     = r_in4;
  assign state_o = r_state;

endmodule

// File: tb/tb_line_follow_ctrl.sv
// Directed self-checking bench for line_follow_ctrl with small parameters
// (PWM_BITS 4, DUTY_FWD 12, DUTY_TURN 6, LOST_CYCLES 20, OBST_HOLD 5).
module tb_line_follow_ctrl;

  logic       clk;
  logic       rst_n;
  logic       run;
  logic       s1, s2, s3, s4;
  logic       prox;
  logic       en1, in1, in2, en2, in3, in4;
  logic [2:0] state_o;

  int n_checks;
  int n_errors;

  line_follow_ctrl #(
    .PWM_BITS   (4),
    .DUTY_FWD   (12),
    .DUTY_TURN  (6),
    .LOST_CYCLES(20),
    .OBST_HOLD  (5)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .run    (run),
    .s1     (s1),
    .s2     (s2),
    .s3     (s3),
    .s4     (s4),
    .prox   (prox),
    .en1    (en1),
    .in1    (in1),
    .in2    (in2),
    .en2    (en2),
    .in3    (in3),
    .in4    (in4),
    .state_o(state_o)
  );

  // 10-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // advance n clocks and sample 1 unit after the last rising edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_sens(input logic [3:0] pat);
    {s1, s2, s3, s4} = pat;
  endtask

  // count enable-high clocks over one full 16-count PWM period
  task automatic count_en(output int c1, output int c2);
    c1 = 0;
    c2 = 0;
    repeat (16) begin
      tick(1);
      c1 += int'(en1);
      c2 += int'(en2);
    end
  endtask

  initial begin
    int c1, c2, n;
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    run   = 1'b0;
    prox  = 1'b1;
    set_sens(4'b0110);

    // reset state
    #1;
    check_eq("rst_state", 32'(state_o), 32'd0);
    check_eq("rst_outs", 32'({en1, in1, in2, en2, in3, in4}), 32'd0);
    tick(2);
    rst_n = 1'b1;
    tick(3);
    check_eq("idle_state", 32'(state_o), 32'd0);
    check_eq("idle_outs", 32'({en1, in1, in2, en2, in3, in4}), 32'd0);

    // start following
    run = 1'b1;
    n = 0;
    while ((state_o != 3'd1) && (n < 4)) begin
      tick(1);
      n++;
    end
    check_eq("follow_state", 32'(state_o), 32'd1);
    tick(3);
    check_eq("follow_dir", 32'({in1, in2, in3, in4}), 32'b1010);
    count_en(c1, c2);
    check_eq("follow_duty_l", 32'(c1), 32'd12);
    check_eq("follow_duty_r", 32'(c2), 32'd12);

    // veer left, exact two-edge latency
    set_sens(4'b1100);
    tick(1);
    check_eq("veer_lat_k", 32'(state_o), 32'd1);
    tick(1);
    check_eq("veer_lat_k1", 32'(state_o), 32'd1);
    tick(1);
    check_eq("veer_lat_k2", 32'(state_o), 32'd2);
    tick(2);
    count_en(c1, c2);
    check_eq("veer_duty_l", 32'(c1), 32'd6);
    check_eq("veer_duty_r", 32'(c2), 32'd12);

    // line lost: search pivot left, then halt after 20 clocks
    set_sens(4'b0000);
    tick(3);
    check_eq("search_state", 32'(state_o), 32'd4);
    tick(1);
    check_eq("search_dir", 32'({in1, in2, in3, in4}), 32'b0110);
    n = 1;
    while ((state_o != 3'd6) && (n < 30)) begin
      tick(1);
      n++;
    end
    check_eq("search_len", 32'(n), 32'd20);
    check_eq("halt_state", 32'(state_o), 32'd6);
    tick(1);
    check_eq("halt_brake", 32'({en1, in1, in2, en2, in3, in4}), 32'b111111);

    // leave halt and restart
    run = 1'b0;
    set_sens(4'b0110);
    tick(1);
    check_eq("halt_to_idle", 32'(state_o), 32'd0);
    tick(2);
    run = 1'b1;
    tick(3);
    check_eq("refollow", 32'(state_o), 32'd1);

    // obstacle for 3 clocks, then clear with a single-clock drop
    prox = 1'b0;
    tick(3);
    check_eq("obst_state", 32'(state_o), 32'd5);
    prox = 1'b1;
    tick(2);
    check_eq("obst_brake", 32'({en1, in1, in2, en2, in3, in4}), 32'b111111);
    tick(1);
    prox = 1'b0;
    tick(1);
    prox = 1'b1;
    tick(6);
    check_eq("obst_hold", 32'(state_o), 32'd5);
    tick(1);
    check_eq("obst_release", 32'(state_o), 32'd1);

    // run low and obstacle seen in the same clock: run wins
    prox = 1'b0;
    tick(2);
    check_eq("pre_tie", 32'(state_o), 32'd1);
    run = 1'b0;
    tick(1);
    check_eq("tie_state", 32'(state_o), 32'd0);
    tick(1);
    check_eq("tie_outs", 32'({en1, in1, in2, en2, in3, in4}), 32'd0);

    // veer right, search pivots right, then async reset mid-search
    prox = 1'b1;
    set_sens(4'b0011);
    tick(3);
    run = 1'b1;
    tick(1);
    check_eq("r_follow", 32'(state_o), 32'd1);
    tick(1);
    check_eq("veer_r_state", 32'(state_o), 32'd3);
    set_sens(4'b0000);
    tick(3);
    check_eq("search_r_state", 32'(state_o), 32'd4);
    tick(1);
    check_eq("search_r_dir", 32'({in1, in2, in3, in4}), 32'b1001);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_outs", 32'({en1, in1, in2, en2, in3, in4}), 32'd0);
    check_eq("async_rst_state", 32'(state_o), 32'd0);
    tick(2);
    run = 1'b0;
    rst_n = 1'b1;
    tick(3);
    run = 1'b1;
    tick(1);
    check_eq("post_rst_follow", 32'(state_o), 32'd1);
    tick(1);
    check_eq("post_rst_search", 32'(state_o), 32'd4);
    tick(1);
    check_eq("lastdir_reset_l", 32'({in1, in2, in3, in4}), 32'b0110);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
